// File: rtl/pu_ia_ic_ctrl.sv
// Instruction-cache sequencer: lookup/refill on port 0, invalidate and sweep on port 1.
// Optional hit/miss counters are enabled with `define PU_IC_PERF_CNT_EN.
module pu_ia_ic_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                on,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_ack,
  output logic [DATA_W-1:0]   fetch_data,
  input  logic                inv_req,
  input  logic [ADDR_W-1:0]   inv_addr,
  output logic                inv_ack,
  input  logic                flush_req,
  output logic                busy,
  output logic                bus_req,
  output logic [ADDR_W-1:0]   bus_addr,
  input  logic                bus_gnt,
  input  logic                bus_rdy,
  input  logic [DATA_W-1:0]   bus_rd_data,
  output logic [INDEX_W-1:0]  rw_index,
  output logic                wr_en,
  output logic [TAG_W-1:0]    wr_ptag,
  output logic                wr_valid,
  output logic [DATA_W-1:0]   wr_data,
  input  logic [TAG_W-1:0]    rd_ptag,
  input  logic                rd_valid,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [INDEX_W-1:0]  inv_index,
`ifdef PU_IC_PERF_CNT_EN
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
`endif
  output logic                inv_wr_en
);

  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_t;

  state_t              state, state_n;
  logic [INDEX_W-1:0]  cnt;
  logic                on_q, inv_hit, inv_ack_q;
  logic [INDEX_W-1:0]  f_index, i_index;
  logic [TAG_W-1:0]    f_tag;
  logic                sweep_last, flush_go, inv_go, inv_match, hit, in_miss;
  logic                unused_addr_bits;

  assign f_index    = fetch_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign f_tag      = fetch_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign i_index    = inv_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign unused_addr_bits = ^{fetch_addr[OFFSET_W-1:0], inv_addr[ADDR_W-1:OFFSET_W+INDEX_W],
                              inv_addr[OFFSET_W-1:0]};

  assign sweep_last = (cnt == {INDEX_W{1'b1}});
  assign flush_go   = (state == IDLE) && flush_req;
  assign in_miss    = (state == MISS_REQ) || (state == MISS_WAIT);
  // Invalidates alternate with their ack cycle; a flush in IDLE absorbs them.
  assign inv_go     = inv_req && !inv_ack_q && (state != INIT) && !flush_go;
  assign inv_match  = inv_go && in_miss && (i_index == f_index);
  assign hit        = rd_valid && (rd_ptag == f_tag);
  assign busy       = (state == INIT);
  assign inv_ack    = inv_ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      on_q      <= 1'b0;
      inv_hit   <= 1'b0;
      inv_ack_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= (state == INIT) ? cnt + 1'b1 : '0;
      if (state == IDLE) on_q <= on;
      if (state == IDLE)  inv_hit <= 1'b0;
      else if (inv_match) inv_hit <= 1'b1;
      // An invalidate held across a sweep is satisfied by the sweep itself.
      inv_ack_q <= inv_go || ((state == INIT) && sweep_last && inv_req);
    end
  end

  always_comb begin
    state_n    = state;
    fetch_ack  = 1'b0;
    fetch_data = '0;
    bus_req    = 1'b0;
    bus_addr   = '0;
    rw_index   = '0;
    wr_en      = 1'b0;
    wr_ptag    = '0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    inv_wr_en  = inv_go;
    inv_index  = inv_go ? i_index : '0;
    case (state)
      INIT: begin
        inv_wr_en = !rst;
        inv_index = cnt;
        if (sweep_last) state_n = IDLE;
      end
      IDLE: begin
        rw_index = f_index;
        if (flush_req)      state_n = INIT;
        else if (fetch_req) state_n = on ? LOOKUP : MISS_REQ;
      end
      LOOKUP: begin
        rw_index = f_index;
        if (hit) begin
          fetch_ack  = 1'b1;
          fetch_data = rd_data;
          state_n    = IDLE;
        end else begin
          state_n    = MISS_REQ;
        end
      end
      MISS_REQ: begin
        rw_index = f_index;
        bus_req  = 1'b1;
        bus_addr = {fetch_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (bus_gnt) state_n = MISS_WAIT;
      end
      MISS_WAIT: begin
        rw_index = f_index;
        if (bus_rdy) begin
          fetch_ack  = 1'b1;
          fetch_data = bus_rd_data;
          state_n    = IDLE;
          if (on_q) begin
            wr_en    = 1'b1;
            wr_ptag  = f_tag;
            wr_data  = bus_rd_data;
            // A racing invalidate leaves the refilled line invalid.
            wr_valid = !(inv_hit || inv_match);
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

`ifdef PU_IC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (flush_go) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit && (hit_cnt != 32'hFFFF_FFFF))         hit_cnt  <= hit_cnt + 1'b1;
      else if (!hit && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pu_ia_ic_ctrl.sv
// Bench for pu_ia_ic_ctrl: array and bus models, directed vector table, corner sequences,
// and random fetch/invalidate traffic against an index->tag cache model.
module tb_pu_ia_ic_ctrl;
  localparam int TAG_W = 22;
  localparam int LINES = 256;

  logic        clk, rst, on, fetch_req, inv_req, flush_req;
  logic [31:0] fetch_addr, inv_addr;
  logic        fetch_ack, inv_ack, busy, bus_req, bus_gnt, bus_rdy;
  logic [31:0] fetch_data, bus_addr, bus_rd_data;
  logic [7:0]  rw_index, inv_index;
  logic        wr_en, wr_valid, rd_valid, inv_wr_en;
  logic [21:0] wr_ptag, rd_ptag;
  logic [31:0] wr_data, rd_data;
`ifdef PU_IC_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  pu_ia_ic_ctrl dut (
    .clk(clk), .rst(rst), .on(on), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .inv_req(inv_req), .inv_addr(inv_addr),
    .inv_ack(inv_ack), .flush_req(flush_req), .busy(busy), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_gnt(bus_gnt), .bus_rdy(bus_rdy), .bus_rd_data(bus_rd_data),
    .rw_index(rw_index), .wr_en(wr_en), .wr_ptag(wr_ptag), .wr_valid(wr_valid),
    .wr_data(wr_data), .rd_ptag(rd_ptag), .rd_valid(rd_valid), .rd_data(rd_data),
    .inv_index(inv_index),
`ifdef PU_IC_PERF_CNT_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .inv_wr_en(inv_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_1004) return 32'h2402_0001;
    return w * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Tag/valid/data arrays: port 0 read/write, port 1 clears; preload leaves stale valid lines.
  logic [TAG_W-1:0] tag_arr [LINES];
  logic             val_arr [LINES];
  logic [31:0]      dat_arr [LINES];
  logic             preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < LINES; i++) begin
        tag_arr[i] <= TAG_W'(i * 3 + 1);
        val_arr[i] <= 1'b1;
        dat_arr[i] <= ~32'(i);
      end
      rd_ptag <= '0; rd_valid <= 1'b0; rd_data <= '0;
    end else begin
      rd_ptag  <= tag_arr[rw_index];
      rd_valid <= val_arr[rw_index];
      rd_data  <= dat_arr[rw_index];
      if (wr_en) begin
        tag_arr[rw_index] <= wr_ptag;
        val_arr[rw_index] <= wr_valid;
        dat_arr[rw_index] <= wr_data;
      end
      if (inv_wr_en) begin
        tag_arr[inv_index] <= '0;
        val_arr[inv_index] <= 1'b0;
      end
    end
  end

  // Bus: grant after gnt_lo..gnt_hi cycles, data rdy_lo..rdy_hi cycles after grant.
  int gnt_lo = 0, gnt_hi = 2, rdy_lo = 0, rdy_hi = 3;
  initial begin
    logic [31:0] baddr;
    bus_gnt = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_req && !rst) begin
        baddr = bus_addr;
        repeat ($urandom_range(gnt_hi, gnt_lo)) begin @(posedge clk); #1; end
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        repeat ($urandom_range(rdy_hi, rdy_lo)) begin @(posedge clk); #1; end
        bus_rdy = 1'b1; bus_rd_data = mem_word(baddr);
        @(posedge clk); #1;
        bus_rdy = 1'b0; bus_rd_data = '0;
      end
    end
  end

  int          bus_cnt = 0, wr_cnt = 0;
  logic [31:0] lb_addr, lw_data;
  logic [7:0]  lw_idx;
  logic [21:0] lw_tag;
  logic        lw_val;
  always @(negedge clk) begin
    if (!rst && bus_req && bus_gnt) begin
      bus_cnt <= bus_cnt + 1;
      lb_addr <= bus_addr;
    end
    if (!rst && wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      lw_idx  <= rw_index; lw_tag <= wr_ptag; lw_val <= wr_valid; lw_data <= wr_data;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic do_fetch(input logic o, input logic [31:0] a, output logic [31:0] d,
                          output int lat);
    on = o; fetch_addr = a; fetch_req = 1'b1; d = '0; lat = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (fetch_ack) begin d = fetch_data; lat = c; break; end
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic do_inv(input logic [31:0] a, output int lat);
    inv_addr = a; inv_req = 1'b1; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (inv_ack) begin lat = c; break; end
    end
    @(posedge clk); #1;
    inv_req = 1'b0;
  endtask

  task automatic run_fetch(input string nm, input logic o, input logic [31:0] a,
                           input bit miss, input bit wr, input bit val);
    int b0, w0, lat;
    logic [31:0] d;
    b0 = bus_cnt; w0 = wr_cnt;
    do_fetch(o, a, d, lat);
    chk({nm, "_acked"}, lat != 0, 1);
    chk({nm, "_data"}, d, mem_word(a));
    chk({nm, "_busreads"}, bus_cnt - b0, miss);
    chk({nm, "_writes"}, wr_cnt - w0, wr);
    if (!miss) chk({nm, "_hitlat"}, lat, 2);
    if (miss) chk({nm, "_busaddr"}, lb_addr, {a[31:2], 2'b00});
    if (wr) begin
      chk({nm, "_wridx"}, lw_idx, a[9:2]);
      chk({nm, "_wrtag"}, lw_tag, a[31:10]);
      chk({nm, "_wrval"}, lw_val, val);
      chk({nm, "_wrdata"}, lw_data, mem_word(a));
    end
  endtask

  typedef struct { logic on; logic [31:0] addr; bit miss; bit wr; } vec_t;
  vec_t vecs[8];

  initial begin
    int lat, cyc, err, b0, w0, k;
    logic [31:0] d, a;
    logic o, we_s, ack_s;
    logic [7:0] idx_s;
    logic [21:0] mtag [int];
    int m_hit, m_miss;

    vecs[0] = '{1'b1, 32'h0000_1004, 1, 1};  // cold miss, refill index 1 tag 4
    vecs[1] = '{1'b1, 32'h0000_1004, 0, 0};  // hit
    vecs[2] = '{1'b1, 32'h0000_2004, 1, 1};  // same index, tag 8
    vecs[3] = '{1'b1, 32'h0000_2004, 0, 0};
    vecs[4] = '{1'b1, 32'h0000_1004, 1, 1};  // evicted
    vecs[5] = '{1'b0, 32'h0000_0040, 1, 0};  // bypass
    vecs[6] = '{1'b0, 32'h0000_0040, 1, 0};
    vecs[7] = '{1'b1, 32'h0000_1004, 0, 0};  // contents kept while off

    rst = 1'b1; preload = 1'b1; on = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    inv_req = 1'b0; inv_addr = '0; flush_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_fetch_ack", fetch_ack, 0);
    chk("rst_inv_ack", inv_ack, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_inv_wr_en", inv_wr_en, 0);
    chk("rst_outs_zero", {fetch_data, bus_addr, rw_index, inv_index}, 0);
    preload = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    err = 0;
    for (int i = 0; i < LINES; i++) begin
      @(negedge clk);
      if (!(busy && inv_wr_en && inv_index == 8'(i))) err++;
    end
    chk("sweep_sequence_errs", err, 0);
    @(negedge clk);
    chk("busy_after_sweep", busy, 0);
    chk("inv_wr_en_after_sweep", inv_wr_en, 0);
    err = 0;
    for (int i = 0; i < LINES; i++) if (val_arr[i]) err++;
    chk("lines_valid_after_sweep", err, 0);
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++)
      run_fetch($sformatf("vec%0d", v), vecs[v].on, vecs[v].addr, vecs[v].miss,
                vecs[v].wr, 1'b1);
`ifdef PU_IC_PERF_CNT_EN
    chk("perf_hits_table", hit_cnt, 3);
    chk("perf_miss_table", miss_cnt, 3);
`endif

    // Invalidate of the refilling line while the refill is outstanding.
    gnt_lo = 0; gnt_hi = 0; rdy_lo = 6; rdy_hi = 6;
    run_fetch("t5_pre", 1'b1, 32'h0000_2004, 1, 1, 1'b1);
    b0 = bus_cnt; w0 = wr_cnt;
    we_s = 1'b0; idx_s = '0; ack_s = 1'b0;
    fork
      do_fetch(1'b1, 32'h0000_1004, d, lat);
      begin
        cyc = 0;
        while (!(bus_req && bus_gnt) && cyc < 50) begin @(negedge clk); cyc++; end
        @(posedge clk); #1;
        inv_addr = 32'h0000_1004; inv_req = 1'b1;
        @(negedge clk); we_s = inv_wr_en; idx_s = inv_index;
        @(negedge clk); ack_s = inv_ack;
        @(posedge clk); #1;
        inv_req = 1'b0;
      end
    join
    chk("t5_grant_seen", cyc < 50, 1);
    chk("t5_inv_wr_en", we_s, 1);
    chk("t5_inv_index", idx_s, 1);
    chk("t5_inv_ack", ack_s, 1);
    chk("t5_data", d, 32'h2402_0001);
    chk("t5_busreads", bus_cnt - b0, 1);
    chk("t5_writes", wr_cnt - w0, 1);
    chk("t5_wr_valid", lw_val, 0);
    run_fetch("t5_refetch", 1'b1, 32'h0000_1004, 1, 1, 1'b1);
    gnt_lo = 0; gnt_hi = 2; rdy_lo = 0; rdy_hi = 3;

    do_inv(32'h0000_1004, lat);
    chk("idle_inv_lat", lat, 2);
    run_fetch("after_inv", 1'b1, 32'h0000_1004, 1, 1, 1'b1);
    run_fetch("after_inv_hit", 1'b1, 32'h0000_1004, 0, 0, 1'b1);

    // Flush with an invalidate held in the same IDLE cycle.
    inv_addr = 32'h0000_0008; inv_req = 1'b1; flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    cyc = 0;
    while (!inv_ack && cyc < 400) begin @(posedge clk); #1; cyc++; end
    chk("flush_inv_ack_cycle", cyc, 256);
    chk("flush_busy_done", busy, 0);
    @(posedge clk); #1;
    inv_req = 1'b0;
`ifdef PU_IC_PERF_CNT_EN
    chk("perf_hits_flushed", hit_cnt, 0);
    chk("perf_miss_flushed", miss_cnt, 0);
`endif
    run_fetch("after_flush", 1'b1, 32'h0000_1004, 1, 1, 1'b1);

    // Random traffic against an index->tag model; the flush above emptied the cache.
    mtag[1] = 22'h4;
    m_hit = 0; m_miss = 1;
    for (k = 0; k < 150; k++) begin
      a = (32'($urandom_range(3, 0)) << 10) | (32'($urandom_range(7, 0)) << 2) |
          32'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) begin
        do_inv(a, lat);
        chk("rnd_inv_lat", lat, 2);
        mtag.delete(int'(a[9:2]));
      end else begin
        o = ($urandom_range(7, 0) != 0);
        if (o && mtag.exists(int'(a[9:2])) && mtag[int'(a[9:2])] == a[31:10]) begin
          run_fetch("rnd_hit", o, a, 0, 0, 1'b1);
          m_hit++;
        end else begin
          run_fetch(o ? "rnd_miss" : "rnd_bypass", o, a, 1, o, 1'b1);
          if (o) begin mtag[int'(a[9:2])] = a[31:10]; m_miss++; end
        end
      end
    end
`ifdef PU_IC_PERF_CNT_EN
    chk("perf_hits_random", hit_cnt, m_hit);
    chk("perf_miss_random", miss_cnt, m_miss);
`endif

    // Reset during a pending refill request.
    gnt_lo = 30; gnt_hi = 30;
    on = 1'b0; fetch_addr = 32'h0000_0500; fetch_req = 1'b1;
    cyc = 0;
    while (!bus_req && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rst_mid_req_seen", bus_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_bus_req_drop", bus_req, 0);
    chk("rst_mid_busy", busy, 1);
    fetch_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    while (busy && cyc < 400) begin @(posedge clk); #1; cyc++; end
    chk("rst_mid_sweep_len", cyc, 256);
    chk("rst_mid_no_ack", fetch_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
